// File: rtl/vga_timing_gen.sv
// Raster timing generator: waits for a debounced clks_valid, then produces
// registered hsync/vsync/de, pixel coordinates and line/frame strobes.
module vga_timing_gen #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   SYNC_CYCLES = 4
) (
    input  logic       CLK_25M,
    input  logic       RST,
    input  logic       clks_valid,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] px_x,
    output logic [9:0] px_y,
    output logic       line_start,
    output logic       frame_start,
    output logic       running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG     = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG     = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]  SYNC_LAST  = 4'(SYNC_CYCLES - 1);
    localparam logic [3:0]  SYNC_SAT   = 4'(SYNC_CYCLES);

    localparam logic [0:0] ST_WAIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || SYNC_CYCLES < 1 || SYNC_CYCLES > 15) begin : g_bad_config
            $error("vga_timing_gen: totals must be <= 1024 and SYNC_CYCLES in 1..15");
        end
    endgenerate

    logic [0:0] state_r;
    logic [0:0] state_s;
    logic [3:0] debounce_r;
    logic [3:0] debounce_s;
    logic       run_s;
    logic [9:0] x_s;
    logic [9:0] y_s;
    logic       de_s;
    logic       hs_act_s;
    logic       vs_act_s;

    // Next state, debounce count and next raster position (position is 0 outside RUN).
    always_comb begin
        state_s    = state_r;
        debounce_s = debounce_r;
        run_s      = 1'b0;
        x_s        = 10'd0;
        y_s        = 10'd0;
        case (state_r)
            ST_WAIT: begin
                if (clks_valid) begin
                    if (debounce_r >= SYNC_LAST) begin
                        state_s    = ST_RUN;
                        debounce_s = SYNC_SAT;
                        run_s      = 1'b1;
                    end else begin
                        debounce_s = debounce_r + 4'd1;
                    end
                end else begin
                    debounce_s = 4'd0;
                end
            end
            ST_RUN: begin
                if (clks_valid) begin
                    run_s = 1'b1;
                    if (px_x == H_LAST) begin
                        x_s = 10'd0;
                        y_s = (px_y == V_LAST) ? 10'd0 : px_y + 10'd1;
                    end else begin
                        x_s = px_x + 10'd1;
                        y_s = px_y;
                    end
                end else begin
                    state_s    = ST_WAIT;
                    debounce_s = 4'd0;
                end
            end
            default: begin
                state_s    = ST_WAIT;
                debounce_s = 4'd0;
            end
        endcase
    end

    // Region decode of the next position so every output lines up with px_x/px_y.
    always_comb begin
        de_s     = run_s && ({1'b0, x_s} < H_ACT_END) && ({1'b0, y_s} < V_ACT_END);
        hs_act_s = run_s && ({1'b0, x_s} >= HS_BEG) && ({1'b0, x_s} < HS_END);
        vs_act_s = run_s && ({1'b0, y_s} >= VS_BEG) && ({1'b0, y_s} < VS_END);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK_25M) begin
        if (RST) begin
            state_r     <= ST_WAIT;
            debounce_r  <= 4'd0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            px_x        <= 10'd0;
            px_y        <= 10'd0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            state_r     <= state_s;
            debounce_r  <= debounce_s;
            hsync       <= hs_act_s ? HS_POL : ~HS_POL;
            vsync       <= vs_act_s ? VS_POL : ~VS_POL;
            de          <= de_s;
            px_x        <= x_s;
            px_y        <= y_s;
            line_start  <= run_s && (x_s == 10'd0);
            frame_start <= run_s && (x_s == 10'd0) && (y_s == 10'd0);
            running     <= run_s;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-mode instance and a reduced-geometry
// instance, checked by vector table, hand sequences and a reference model.
module tb_vga_timing_gen;

    localparam int B_HA = 16, B_HFP = 3, B_HSW = 4, B_HBP = 5;
    localparam int B_VA = 12, B_VFP = 2, B_VSW = 2, B_VBP = 3;
    localparam int B_SC = 3;
    localparam int B_HT = B_HA + B_HFP + B_HSW + B_HBP;
    localparam int B_VT = B_VA + B_VFP + B_VSW + B_VBP;

    typedef struct packed {
        logic       run;
        logic       fs;
        logic       ls;
        logic       de;
        logic       hs;
        logic       vs;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    typedef struct {
        int   ha, hfp, hsw, hbp, va, vfp, vsw, vbp, sc;
        logic hpol, vpol;
    } geom_t;

    typedef struct {
        bit run;
        int cnt;
        int t;
    } mstate_t;

    typedef struct {
        logic rst;
        logic v;
        obs_t e;
    } vec_t;

    logic CLK_25M = 1'b0;
    logic rst_a, valid_a, rst_b, valid_b;
    logic hsync_a, vsync_a, de_a, line_start_a, frame_start_a, running_a;
    logic hsync_b, vsync_b, de_b, line_start_b, frame_start_b, running_b;
    logic [9:0] px_x_a, px_y_a, px_x_b, px_y_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK_25M = ~CLK_25M;

    vga_timing_gen dut_a (
        .CLK_25M(CLK_25M), .RST(rst_a), .clks_valid(valid_a),
        .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .px_x(px_x_a), .px_y(px_y_a),
        .line_start(line_start_a), .frame_start(frame_start_a), .running(running_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HSW), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VSW), .V_BP(B_VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .SYNC_CYCLES(B_SC)
    ) dut_b (
        .CLK_25M(CLK_25M), .RST(rst_b), .clks_valid(valid_b),
        .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .px_x(px_x_b), .px_y(px_y_b),
        .line_start(line_start_b), .frame_start(frame_start_b), .running(running_b)
    );

    // Reference model: raster position is simply elapsed RUN cycles split by division.
    function automatic mstate_t model_next(mstate_t m, logic rst, logic v, geom_t g);
        mstate_t n = m;
        if (rst) begin
            n.run = 1'b0; n.cnt = 0; n.t = 0;
        end else if (!m.run) begin
            if (v) begin
                n.cnt = m.cnt + 1;
                if (n.cnt >= g.sc) begin n.run = 1'b1; n.t = 0; end
            end else begin
                n.cnt = 0;
            end
        end else if (!v) begin
            n.run = 1'b0; n.cnt = 0;
        end else begin
            n.t = m.t + 1;
        end
        return n;
    endfunction

    function automatic obs_t model_out(mstate_t m, geom_t g);
        obs_t o;
        int ht, vt, x, y;
        ht = g.ha + g.hfp + g.hsw + g.hbp;
        vt = g.va + g.vfp + g.vsw + g.vbp;
        o = '0;
        o.hs = ~g.hpol;
        o.vs = ~g.vpol;
        if (m.run) begin
            x = m.t % ht;
            y = (m.t / ht) % vt;
            o.run = 1'b1;
            o.x = 10'(x);
            o.y = 10'(y);
            o.de = (x < g.ha) && (y < g.va);
            o.hs = (x >= g.ha + g.hfp && x < g.ha + g.hfp + g.hsw) ? g.hpol : ~g.hpol;
            o.vs = (y >= g.va + g.vfp && y < g.va + g.vfp + g.vsw) ? g.vpol : ~g.vpol;
            o.ls = (x == 0);
            o.fs = (x == 0) && (y == 0);
        end
        return o;
    endfunction

    function automatic obs_t act_a();
        return {running_a, frame_start_a, line_start_a, de_a, hsync_a, vsync_a, px_x_a, px_y_a};
    endfunction

    function automatic obs_t act_b();
        return {running_b, frame_start_b, line_start_b, de_b, hsync_b, vsync_b, px_x_b, px_y_b};
    endfunction

    task automatic check_obs(string name, obs_t got, obs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got run=%0b fs=%0b ls=%0b de=%0b hs=%0b vs=%0b x=%0d y=%0d, expected run=%0b fs=%0b ls=%0b de=%0b hs=%0b vs=%0b x=%0d y=%0d",
                     name, got.run, got.fs, got.ls, got.de, got.hs, got.vs, got.x, got.y,
                     exp.run, exp.fs, exp.ls, exp.de, exp.hs, exp.vs, exp.x, exp.y);
        end
    endtask

    task automatic check_val(string name, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_25M);
        #1;
    endtask

    task automatic wait_pos_b(int x, int y, int budget, string name);
        int k = 0;
        while (!(running_b && int'(px_x_b) == x && int'(px_y_b) == y) && k < budget) begin
            step();
            k++;
        end
        n_tests++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL %s: position (%0d,%0d) not reached within %0d cycles", name, x, y, budget);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        geom_t   ga, gb;
        mstate_t ma, mb;
        vec_t    tbl[$];
        obs_t    rst_obs, start_obs, x1_obs, x2_obs;
        int de_cnt, hs_cnt, hs_first, hs_last, ls_prev, ls_gap, ls_n;
        int de_viol, vs_viol, vs_cnt, vs_edge_viol, wraps, fs_prev, fs_gap, prev_x, prev_y;
        logic vs_last;

        ga = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0, 1'b0};
        gb = '{B_HA, B_HFP, B_HSW, B_HBP, B_VA, B_VFP, B_VSW, B_VBP, B_SC, 1'b0, 1'b0};
        rst_obs   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0};
        start_obs = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
        x1_obs    = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd1, 10'd0};
        x2_obs    = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd2, 10'd0};
        rst_a = 1'b1; valid_a = 1'b0; rst_b = 1'b1; valid_b = 1'b0;

        // Power-up, RST precedence, debounce glitch and drop on the default instance.
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, 1'b0, rst_obs});
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 1'b1, rst_obs});
        tbl.push_back('{1'b0, 1'b1, start_obs});
        tbl.push_back('{1'b0, 1'b1, x1_obs});
        tbl.push_back('{1'b0, 1'b1, x2_obs});
        tbl.push_back('{1'b1, 1'b1, rst_obs});
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 1'b1, rst_obs});
        tbl.push_back('{1'b0, 1'b0, rst_obs});
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 1'b1, rst_obs});
        tbl.push_back('{1'b0, 1'b1, start_obs});
        tbl.push_back('{1'b0, 1'b1, x1_obs});
        tbl.push_back('{1'b0, 1'b0, rst_obs});
        tbl.push_back('{1'b0, 1'b1, rst_obs});

        for (int i = 0; i < tbl.size(); i++) begin
            rst_a = tbl[i].rst;
            valid_a = tbl[i].v;
            step();
            check_obs($sformatf("table[%0d]", i), act_a(), tbl[i].e);
        end

        // Line timing on the default instance.
        rst_a = 1'b1; valid_a = 1'b1;
        step();
        rst_a = 1'b0;
        for (int k = 0; k < 20 && !running_a; k++) step();
        check_obs("line_restart_a", act_a(), start_obs);
        de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; ls_prev = -1; ls_gap = 0; ls_n = 0;
        for (int c = 0; c < 1600; c++) begin
            if (px_y_a == 10'd0 && de_a) de_cnt++;
            if (px_y_a == 10'd0 && !hsync_a) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(px_x_a);
                hs_last = int'(px_x_a);
            end
            if (line_start_a) begin
                if (ls_prev >= 0) ls_gap = c - ls_prev;
                ls_prev = c;
                ls_n++;
            end
            step();
        end
        check_val("line0_de_cycles", de_cnt, 640);
        check_val("line0_hsync_cycles", hs_cnt, 96);
        check_val("line0_hsync_first_x", hs_first, 656);
        check_val("line0_hsync_last_x", hs_last, 751);
        check_val("line_start_period", ls_gap, 800);
        check_val("line_start_count", ls_n, 2);
        valid_a = 1'b0;

        // Frame timing on the reduced instance.
        rst_b = 1'b0; valid_b = 1'b1;
        for (int k = 0; k < 20 && !running_b; k++) step();
        check_obs("frame_start_b", act_b(), start_obs);
        de_viol = 0; vs_viol = 0; vs_cnt = 0; vs_edge_viol = 0; wraps = 0;
        fs_prev = -1; fs_gap = 0; prev_x = -1; prev_y = -1; vs_last = vsync_b;
        for (int c = 0; c < 1200; c++) begin
            if (int'(px_y_b) >= B_VA && de_b) de_viol++;
            if ((vsync_b == 1'b0) != (int'(px_y_b) >= B_VA + B_VFP && int'(px_y_b) < B_VA + B_VFP + B_VSW)) vs_viol++;
            if (c < B_HT * B_VT && !vsync_b) vs_cnt++;
            if (vsync_b != vs_last && px_x_b != 10'd0) vs_edge_viol++;
            if (prev_x == B_HT - 1 && prev_y == B_VT - 1) begin
                check_val("wrap_x", int'(px_x_b), 0);
                check_val("wrap_y", int'(px_y_b), 0);
                wraps++;
            end
            if (frame_start_b) begin
                if (fs_prev >= 0) fs_gap = c - fs_prev;
                fs_prev = c;
            end
            prev_x = int'(px_x_b); prev_y = int'(px_y_b); vs_last = vsync_b;
            step();
        end
        check_val("de_in_vblank", de_viol, 0);
        check_val("vsync_window", vs_viol, 0);
        check_val("vsync_cycles", vs_cnt, B_VSW * B_HT);
        check_val("vsync_edge_off_x0", vs_edge_viol, 0);
        check_val("frame_start_period", fs_gap, B_HT * B_VT);
        check_val("frame_wraps", wraps, 2);

        // Drop of clks_valid mid-frame, then restart.
        wait_pos_b(10, 5, 1000, "reach_drop_pos");
        valid_b = 1'b0;
        step();
        check_obs("drop_b", act_b(), rst_obs);
        valid_b = 1'b1;
        for (int k = 1; k < B_SC; k++) begin
            step();
            check_val("restart_wait_b", int'(running_b), 0);
        end
        step();
        check_obs("restart_b", act_b(), start_obs);

        // RST during vsync, then normal start.
        wait_pos_b(B_HT - 4, B_VA + B_VFP + 1, 1000, "reach_vsync_pos");
        check_val("vsync_active_b", int'(vsync_b), 0);
        rst_b = 1'b1;
        step();
        check_obs("rst_in_vsync_b", act_b(), rst_obs);
        rst_b = 1'b0;
        for (int k = 1; k < B_SC; k++) begin
            step();
            check_val("rst_restart_wait_b", int'(running_b), 0);
        end
        step();
        check_obs("rst_restart_b", act_b(), start_obs);

        // Randomized stimulus on both instances against the reference model.
        rst_a = 1'b1; valid_a = 1'b0; rst_b = 1'b1; valid_b = 1'b0;
        ma = '{1'b0, 0, 0};
        mb = '{1'b0, 0, 0};
        step();
        ma = model_next(ma, 1'b1, 1'b0, ga);
        mb = model_next(mb, 1'b1, 1'b0, gb);
        check_obs("rand_init_a", act_a(), model_out(ma, ga));
        check_obs("rand_init_b", act_b(), model_out(mb, gb));
        for (int seg = 0; seg < 12; seg++) begin
            int p;
            p = int'($urandom_range(0, 2));
            for (int c = 0; c < 500; c++) begin
                logic ra, va, rb, vb;
                ra = ($urandom_range(0, 999) == 0);
                rb = ($urandom_range(0, 999) == 0);
                va = (p == 0) ? 1'b1 : (p == 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 399) != 0);
                vb = (p == 0) ? 1'b1 : (p == 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 399) != 0);
                rst_a = ra; valid_a = va; rst_b = rb; valid_b = vb;
                step();
                ma = model_next(ma, ra, va, ga);
                mb = model_next(mb, rb, vb, gb);
                check_obs("rand_a", act_a(), model_out(ma, ga));
                check_obs("rand_b", act_b(), model_out(mb, gb));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
